// File: rtl/inst_fetch_queue_pkg.sv
// fetch_pkg: types and constants shared by fetch, the fetch queue and instruction_decompose.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: fetch-side push, decode-side pop, flush and occupancy of the fetch queue.
interface inst_fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
);

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_pc;
    logic [XLEN-1:0]        in_inst;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_pc;
    logic [XLEN-1:0]        out_inst;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );

endinterface

// File: rtl/inst_fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x fetch_entry_t register array, one write port, asynchronous read.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         i_we,
    input  logic [AW-1:0] i_waddr,
    input  fetch_entry_t i_wdata,
    input  logic [AW-1:0] i_raddr,
    output fetch_entry_t o_rdata
);

    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: elastic {pc, inst} FIFO between fetch and decode with single-cycle flush.
// Define FETCH_Q_BYPASS_EN for a combinational empty-queue bypass from in_* to out_*.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_empty;
    logic          w_full;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_wdata;
    fetch_entry_t  w_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

`ifdef FETCH_Q_BYPASS_EN
    assign w_bypass = w_empty && bus.in_valid && !bus.flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed entry taken by decode in the same cycle never enters storage.
    assign w_push  = bus.in_valid && !w_full && !(w_bypass && bus.out_ready);
    assign w_pop   = !w_empty && bus.out_ready;
    assign w_wdata = '{pc: bus.in_pc, inst: bus.in_inst};

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_push && rst_n && !bus.flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty || w_bypass;
    assign bus.out_pc    = w_bypass ? bus.in_pc   : (w_empty ? '0       : w_rdata.pc);
    assign bus.out_inst  = w_bypass ? bus.in_inst : (w_empty ? NOP_INST : w_rdata.inst);
    assign bus.count     = r_count;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (r_count <= CW'(DEPTH));
            assert (!(w_pop && w_empty));
        end
    end

endmodule
